fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage and consumer of the branch unit's redirect outputs (newPC/ctrlFetch/global_reset).
- Generates sequential PCs and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO for decode.
- Applies redirects and soft resets: squashes buffered and in-flight fetches, restarts at the new PC.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset_n release or global_reset.
FIFO_DEPTH, 2, number of {pc,instr} entries buffered toward decode; power of two, min 2.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
global_reset  input  1  synchronous soft reset from branch unit; restarts fetch at RESET_PC.
redirect_valid  input  1  ctrlFetch from branch unit; one-cycle pulse, take redirect_pc.
redirect_pc  input  32  newPC from branch unit; bits[1:0] ignored (treated as 0).
imem_req  output  1  memory request valid.
imem_addr  output  32  word-aligned fetch address.
imem_gnt  input  1  request accepted this cycle.
imem_rvalid  input  1  response data valid; at least 1 cycle after the matching gnt.
imem_rdata  input  32  instruction word.
out_valid  output  1  FIFO head valid to decode.
out_pc  output  32  PC of head instruction.
out_instr  output  32  head instruction.
out_ready  input  1  decode consumes head when out_valid && out_ready.

Behaviour:
- Reset (reset_n=0): imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0, FIFO empty, state=IDLE, fetch_pc=RESET_PC.
- States:
  - IDLE: after reset release, go to REQ on the next edge. imem_req is first high in the second cycle after release.
  - REQ: imem_req=1, imem_addr=fetch_pc.
    - On gnt: record the in-flight PC, fetch_pc += 4, go to WAIT.
  - WAIT: imem_req=0.
    - On rvalid: push {inflight_pc, imem_rdata} into the FIFO.
    - Then REQ if credit is available, else HOLD.
  - HOLD: imem_req=0. Go to REQ when credit is available.
  - DISCARD: in-flight response is squashed. imem_req=0.
    - On rvalid: drop the data, go to REQ.
- Credit and outstanding limit:
  - Credit = (FIFO count + outstanding) < FIFO_DEPTH, where a pop in the same cycle counts as freeing a slot.
  - At most one request outstanding.
- Latency: rvalid at cycle t gives out_valid=1 at t+1, with out_pc/out_instr stable until popped.
- FIFO: push and pop in the same cycle allowed when full or empty; no push is ever dropped. Overflow is impossible by credit.
- PC arithmetic: 32-bit, +4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Redirect (redirect_valid=1, global_reset=0):
  - FIFO flushed; out_valid=0 next cycle.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - In REQ without gnt: imem_addr switches to the new PC next cycle and imem_req stays high.
  - In REQ with gnt the same cycle, or in WAIT: go to DISCARD.
  - Otherwise: go to REQ.
  - A redirect arriving in DISCARD updates fetch_pc only; the state stays DISCARD.
- global_reset: same as redirect, using RESET_PC. Priority: reset_n > global_reset > redirect_valid.
- Simultaneous pop and redirect: the pop is accepted by decode, then the flush applies. No entry survives.
- Simultaneous rvalid and redirect in WAIT: the data is dropped and the state goes to REQ directly, not DISCARD.
- reset_n low mid-transaction: the state machine returns to IDLE. Any later stray rvalid is ignored (rvalid is only honoured in WAIT/DISCARD).

Optional Feature:
FETCH_STATS_EN
- Defined: adds outputs stat_redirects[31:0] and stat_squashed[31:0].
  - stat_redirects counts redirect_valid or global_reset pulses.
  - stat_squashed counts discarded responses plus flushed FIFO entries.
  - Both saturate at 32'hFFFF_FFFF, clear on reset_n, and are not cleared by global_reset.
- Undefined: no ports, no counters; behaviour otherwise identical.

Test Plan:
- Reset release, gnt same cycle as req, rvalid 1 cycle later, out_ready=1 -> imem_addr sequence 0x0,0x4,0x8; out_pc 0x0,0x4,0x8 with matching instr; out_valid 1 cycle after each rvalid.
- out_ready=0, FIFO_DEPTH=2 -> after two responses, imem_req stays 0 (HOLD). Raising out_ready for one cycle -> exactly one new request to 0x8.
- redirect_valid with redirect_pc=0x1003 while in WAIT, rvalid 2 cycles later -> that response dropped, FIFO empty, next imem_addr=0x1000, next out_pc=0x1000.
- redirect_pc=0x200 while REQ and gnt low -> imem_addr=0x200 next cycle, req held high, no DISCARD.
- global_reset and redirect_valid(0x300) in the same cycle -> next fetch address RESET_PC; FIFO flushed.
- fetch_pc=0xFFFF_FFFC -> next fetch address 0x0000_0000. With FETCH_STATS_EN, a flush of 2 buffered entries plus 1 in flight -> stat_squashed increments by 3.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a small {pc,instr} buffer
// toward decode. Redirects and soft resets squash buffered and in-flight
// fetches and restart at the new PC.
// Optional: define FETCH_STATS_EN to add redirect/squash counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        global_reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_redirects,
  output logic [31:0] stat_squashed
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
  localparam logic [2:0] DISCARD = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   inflight_q, inflight_d;
  logic [CW-1:0] count_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [31:0]   pc_mem  [FIFO_DEPTH];
  logic [31:0]   ins_mem [FIFO_DEPTH];

  logic          flush, pop, push;
  logic [31:0]   flush_pc;
  logic [CW-1:0] cnt_pop;

  // global_reset outranks redirect_valid; low address bits are dropped
  assign flush    = global_reset | redirect_valid;
  assign flush_pc = global_reset ? RESET_PC : (redirect_pc & 32'hFFFF_FFFC);
  assign pop      = out_valid & out_ready;
  // a squashing cycle never pushes, even if data lands in WAIT
  assign push     = (state_q == WAIT) & imem_rvalid & ~flush;
  // occupancy after this cycle's pop; a pop frees its slot immediately
  assign cnt_pop  = count_q - CW'(pop);

  assign imem_req  = (state_q == REQ);
  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? pc_mem[rd_q]  : 32'h0;
  assign out_instr = out_valid ? ins_mem[rd_q] : 32'h0;

  // next state / fetch pc; the flush override decides if a response is owed
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: if (imem_gnt) begin
        inflight_d = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
        state_d    = WAIT;
      end
      WAIT:    if (imem_rvalid) state_d = (cnt_pop < DEPTH_C - CW'(1)) ? REQ : HOLD;
      HOLD:    if (cnt_pop < DEPTH_C) state_d = REQ;
      DISCARD: if (imem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      fetch_pc_d = flush_pc;
      case (state_q)
        REQ:     state_d = imem_gnt    ? DISCARD : REQ;
        WAIT:    state_d = imem_rvalid ? REQ     : DISCARD;
        DISCARD: state_d = imem_rvalid ? REQ     : DISCARD;
        default: state_d = REQ;
      endcase
    end
  end

  // control registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      inflight_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
    end
  end

  // fifo pointers and occupancy; flush empties it after this cycle's pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else if (flush) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // fifo storage; contents are only observed while out_valid
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_q]  <= inflight_q;
      ins_mem[wr_q] <= imem_rdata;
    end
  end

`ifdef FETCH_STATS_EN
  logic [CW-1:0] flushed;
  logic          dropped;
  logic [32:0]   sq_sum;
  logic [31:0]   redir_q, sq_q;

  assign flushed = flush ? cnt_pop : '0;
  assign dropped = imem_rvalid & ((state_q == DISCARD) | ((state_q == WAIT) & flush));
  assign sq_sum  = {1'b0, sq_q} + 33'(flushed) + 33'(dropped);
  assign stat_redirects = redir_q;
  assign stat_squashed  = sq_q;

  // saturating counters, cleared only by reset_n
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      redir_q <= '0;
      sq_q    <= '0;
    end else begin
      if (flush && redir_q != 32'hFFFF_FFFF) redir_q <= redir_q + 32'd1;
      sq_q <= sq_sum[32] ? 32'hFFFF_FFFF : sq_sum[31:0];
    end
  end
`endif

endmodule
